// File: rtl/common_pkg.sv
// Shared types for the Quinta pipeline front end.
// Holds the IF/ID bundle, fetch FSM states and the canonical NOP.
package common_pkg;

    typedef logic [31:0] instruction_t;

    localparam instruction_t NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } fetch_state_t;

    typedef struct packed {
        instruction_t instruction;
        logic [31:0]  pc;
        logic         valid;
    } if_id_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Instruction memory port: valid/ready request, valid-only response.
// The fetch stage is the master; the memory is the slave.
interface instruction_fetch_stage_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/instruction_fetch_stage.sv
// Quinta fetch stage: owns the PC, keeps one fetch in flight,
// parks a returned word while decode stalls, flushes on redirect.
module instruction_fetch_stage
    import common_pkg::*;
#(
    parameter logic [31:0]  RESET_PC = 32'h0000_0000,
    parameter instruction_t NOP_WORD = NOP_INSTR
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      branch_taken,
    input  logic [31:0]               branch_target,
    instruction_fetch_stage_if.master imem,
    output instruction_t              instruction,
    output logic [31:0]               pc,
    output logic                      instr_valid
);

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q;
    logic [31:0]  req_pc_q;
    logic         drop_q, drop_d;
    if_id_t       hold_q;
    if_id_t       out_q;

    logic req_valid;
    logic req_fire;
    logic rsp_live;
    logic deliver_rsp;
    logic park_rsp;
    logic deliver_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    // A redirect while a fetch is in flight leaves the state alone
    // and only arms drop, so the stale word is swallowed on return.
    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        unique case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    state_d = S_WAIT;
                    drop_d  = branch_taken;
                end
            end
            S_WAIT: begin
                if (imem.imem_rsp_valid) begin
                    drop_d  = 1'b0;
                    state_d = park_rsp ? S_HOLD : S_REQ;
                end else if (branch_taken) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (branch_taken || !stall) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        req_valid    = (state_q == S_REQ) && !rst;
        req_fire     = req_valid && imem.imem_req_ready;
        rsp_live     = (state_q == S_WAIT) && imem.imem_rsp_valid
                       && !drop_q && !branch_taken;
        deliver_rsp  = rsp_live && !stall;
        park_rsp     = rsp_live && stall;
        deliver_hold = (state_q == S_HOLD) && hold_q.valid
                       && !stall && !branch_taken;
    end

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = fetch_pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            hold_q     <= '{instruction: NOP_WORD, pc: RESET_PC, valid: 1'b0};
            out_q      <= '{instruction: NOP_WORD, pc: RESET_PC, valid: 1'b0};
        end else begin
            if (branch_taken) begin
                fetch_pc_q <= word_align(branch_target);
            end else if (req_fire) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end

            if (req_fire) begin
                req_pc_q <= fetch_pc_q;
            end

            if (branch_taken || deliver_hold) begin
                hold_q.valid <= 1'b0;
            end else if (park_rsp) begin
                hold_q <= '{instruction: imem.imem_rsp_data,
                            pc: req_pc_q, valid: 1'b1};
            end

            if (branch_taken) begin
                out_q <= '{instruction: NOP_WORD, pc: out_q.pc, valid: 1'b0};
            end else if (deliver_rsp) begin
                out_q <= '{instruction: imem.imem_rsp_data,
                           pc: req_pc_q, valid: 1'b1};
            end else if (deliver_hold) begin
                out_q <= '{instruction: hold_q.instruction,
                           pc: hold_q.pc, valid: 1'b1};
            end else if (!stall) begin
                out_q <= '{instruction: NOP_WORD, pc: out_q.pc, valid: 1'b0};
            end
        end
    end

    assign instruction = out_q.instruction;
    assign pc          = out_q.pc;
    assign instr_valid = out_q.valid;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios then random
// traffic, checked against a transaction-level fetch model.
module tb_instruction_fetch_stage;
    import common_pkg::*;

    localparam logic [31:0] RPC = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         stall;
    logic         branch_taken;
    logic [31:0]  branch_target;
    instruction_t instruction;
    logic [31:0]  pc;
    logic         instr_valid;

    instruction_fetch_stage_if ifc ();

    instruction_fetch_stage #(
        .RESET_PC (RPC),
        .NOP_WORD (NOP_INSTR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem          (ifc),
        .instruction   (instruction),
        .pc            (pc),
        .instr_valid   (instr_valid)
    );

    int checks = 0;
    int errors = 0;

    // reference model: next fetch address, one in-flight fetch
    // (alive or killed by redirect), one parked word, IF/ID view
    logic [31:0] m_fetch = RPC;
    bit          m_busy = 0;
    bit          m_live = 0;
    logic [31:0] m_addr = '0;
    bit          m_pend = 0;
    logic [31:0] m_pend_pc = '0;
    bit          m_oval = 0;
    logic [31:0] m_opc = RPC;
    logic [31:0] m_oins = NOP_INSTR;

    // memory responder
    bit          mem_busy = 0;
    logic [31:0] mem_addr = '0;
    int          mem_cnt = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;

    bit          last_req_valid;
    logic [31:0] last_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2] ^ 30'h2AAA_5555, 2'b11};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit st, input bit br,
                       input logic [31:0] tgt, input bit rdy);
        bit          rsp;
        bit          acc;
        bit          live;
        logic [31:0] wpc;
        @(negedge clk);
        rst           = r;
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        rsp = mem_busy && (mem_cnt == 0);
        ifc.imem_rsp_valid = rsp;
        ifc.imem_rsp_data  = rsp ? mem_word(mem_addr) : $urandom;
        ifc.imem_req_ready = rdy && !mem_busy;
        #1;
        acc = ifc.imem_req_valid && ifc.imem_req_ready;
        last_req_valid = ifc.imem_req_valid;
        last_addr      = ifc.imem_req_addr;
        check("req_valid", 32'(ifc.imem_req_valid),
              32'(!r && !m_busy && !m_pend));
        if (!r && ifc.imem_req_valid) begin
            check("req_addr", ifc.imem_req_addr, m_fetch);
        end
        @(posedge clk);
        #1;
        if (rsp) mem_busy = 0;
        else if (mem_busy) mem_cnt--;
        if (acc) begin
            mem_busy = 1;
            mem_addr = last_addr;
            mem_cnt  = int'($urandom_range(lat_hi - 1, lat_lo - 1));
        end
        if (r) begin
            m_fetch = RPC; m_busy = 0; m_pend = 0;
            m_oval = 0; m_opc = RPC; m_oins = NOP_INSTR;
        end else begin
            live = 0;
            wpc  = m_addr;
            if (rsp && m_busy) begin
                live   = m_live && !br;
                m_busy = 0;
            end
            if (br) begin
                m_pend = 0; m_live = 0; m_oval = 0; m_oins = NOP_INSTR;
            end else if (st) begin
                if (live) begin m_pend = 1; m_pend_pc = wpc; end
            end else if (m_pend) begin
                m_pend = 0; m_oval = 1;
                m_opc = m_pend_pc; m_oins = mem_word(m_pend_pc);
            end else if (live) begin
                m_oval = 1; m_opc = wpc; m_oins = mem_word(wpc);
            end else begin
                m_oval = 0; m_oins = NOP_INSTR;
            end
            if (acc) begin
                m_busy = 1; m_addr = m_fetch; m_live = !br;
            end
            if (br) m_fetch = {tgt[31:2], 2'b00};
            else if (acc) m_fetch = m_fetch + 32'd4;
        end
        check("instr_valid", 32'(instr_valid), 32'(m_oval));
        check("instruction", instruction, m_oins);
        check("pc", pc, m_opc);
    endtask

    task automatic run(input bit st, input bit rdy);
        cyc(0, st, 0, 32'h0, rdy);
    endtask

    initial begin
        bit found;
        rst = 1; stall = 0; branch_taken = 0; branch_target = '0;
        ifc.imem_req_ready = 0;
        ifc.imem_rsp_valid = 0;
        ifc.imem_rsp_data  = '0;

        // reset
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_pc", pc, RPC);
        check("rst_instr", instruction, NOP_INSTR);

        // streaming, 1-cycle latency, wrap past 0xFFFF_FFFC
        run(0, 1);
        check("first_req", last_addr, RPC);
        run(0, 1);
        check("out0_pc", pc, RPC);
        check("out0_valid", 32'(instr_valid), 32'h1);
        run(0, 1);
        check("wrap_req", last_addr, 32'h0);
        check("gap_valid", 32'(instr_valid), 32'h0);
        run(0, 1);
        check("out1_pc", pc, 32'h0);
        run(0, 1);
        run(0, 1);
        check("out2_pc", pc, 32'h4);

        // stall for 5 cycles while the word for 0x8 returns
        run(1, 1);
        run(1, 1);
        for (int i = 0; i < 3; i++) begin
            run(1, 1);
            check("hold_no_req", 32'(last_req_valid), 32'h0);
            check("hold_pc", pc, 32'h4);
        end
        run(0, 1);
        check("unstall_pc", pc, 32'h8);
        check("unstall_valid", 32'(instr_valid), 32'h1);

        // redirect while waiting on a slow response
        lat_lo = 3; lat_hi = 3;
        run(0, 1);
        cyc(0, 0, 1, 32'h103, 1);
        check("redir_flush", 32'(instr_valid), 32'h0);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            run(0, 1);
            if (last_req_valid) begin found = 1; break; end
        end
        check("redir_req_seen", 32'(found), 32'h1);
        check("redir_addr", last_addr, 32'h100);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            run(0, 1);
            if (instr_valid) begin found = 1; break; end
        end
        check("redir_out_seen", 32'(found), 32'h1);
        check("redir_pc", pc, 32'h100);

        // redirect with stall in the same cycle as a response
        lat_lo = 1; lat_hi = 1;
        run(0, 1);
        cyc(0, 1, 1, 32'h200, 1);
        check("rsp_br_valid", 32'(instr_valid), 32'h0);
        check("rsp_br_instr", instruction, NOP_INSTR);
        run(0, 1);
        check("rsp_br_req", last_addr, 32'h200);
        run(0, 1);

        // memory not ready for 4 cycles
        for (int i = 0; i < 4; i++) begin
            run(0, 0);
            check("nrdy_valid", 32'(last_req_valid), 32'h1);
            check("nrdy_addr", last_addr, 32'h204);
        end
        run(0, 1);
        run(0, 1);
        check("nrdy_pc", pc, 32'h204);

        // reset while a fetch is in flight
        lat_lo = 3; lat_hi = 3;
        run(0, 1);
        cyc(1, 0, 0, 0, 1);
        check("mid_rst_valid", 32'(instr_valid), 32'h0);
        run(0, 1);
        check("mid_rst_req", last_addr, RPC);
        run(0, 1);
        check("stale_ignored", 32'(instr_valid), 32'h0);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            run(0, 1);
            if (instr_valid) begin found = 1; break; end
        end
        check("mid_rst_out_seen", 32'(found), 32'h1);
        check("mid_rst_pc", pc, RPC);

        // random traffic
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom % 100) == 0, ($urandom % 100) < 30,
                ($urandom % 100) < 8, $urandom, ($urandom % 100) < 70);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
Front end of the Quinta pipeline. Owns the program counter, issues word fetches to instruction memory over a valid/ready request and valid response interface, and presents (instruction, pc, instr_valid) to the IF/ID boundary consumed by decode. Handles hazard stalls, branch redirects with flush of in-flight fetches, and a one-entry hold buffer so a returned word is never lost while decode is stalled.

Parameters:
RESET_PC, 32'h0000_0000, address of the first fetch after reset
NOP_WORD, 32'h0000_0013, ADDI x0,x0,0; driven on instruction whenever instr_valid=0

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
stall  input  1  hazard unit request to hold IF/ID outputs
branch_taken  input  1  redirect fetch to branch_target this cycle
branch_target  input  32  redirect address; bits [1:0] ignored, forced to 00
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  word-aligned fetch address
imem_rsp_valid  input  1  fetch data valid; at most one response per accepted request, latency >= 1 cycle
imem_rsp_data  input  32  fetched instruction word
instruction  output  instruction_t  instruction to decode
pc  output  32  address of instruction
instr_valid  output  1  instruction/pc hold a real fetched instruction

Behaviour:
- Reset (rst=1 at clk edge): state=S_REQ, fetch_pc=RESET_PC, drop=0, hold buffer empty, instruction=NOP_WORD, pc=RESET_PC, instr_valid=0. imem_req_valid is 0 while rst=1 and is 1 from the first cycle after rst deasserts, with addr RESET_PC. Reset mid-transaction abandons any outstanding request; a response arriving after reset with drop=0 and state S_REQ is ignored.
- At most one outstanding request. imem_req_addr = fetch_pc. fetch_pc wraps modulo 2^32: 0xFFFF_FFFC + 4 = 0x0000_0000.
- FSM:
  - S_REQ: imem_req_valid=1. On imem_req_valid and imem_req_ready, latch req_pc=fetch_pc, fetch_pc+=4, go to S_WAIT.
  - S_WAIT: imem_req_valid=0. On imem_rsp_valid:
    - drop=1: discard the response, clear drop, go to S_REQ.
    - stall=0: instruction<=rsp_data, pc<=req_pc, instr_valid<=1, go to S_REQ. Response-to-output latency is 1 cycle.
    - stall=1: write (rsp_data, req_pc) to the hold buffer and go to S_HOLD.
  - S_HOLD: imem_req_valid=0. When stall=0, move the buffer to the outputs with instr_valid<=1, empty the buffer, go to S_REQ.
- stall=1: instruction, pc and instr_valid keep their values, except on a redirect (see below).
- If no new word is delivered in a cycle with stall=0, instr_valid<=0 and instruction<=NOP_WORD. pc keeps its value.
- branch_taken=1, which has priority over stall and over a same-cycle imem_rsp_valid:
  - fetch_pc <= {branch_target[31:2],2'b00}.
  - Outputs flush: instr_valid<=0, instruction<=NOP_WORD.
  - Hold buffer is cleared.
  - From S_WAIT without a same-cycle response, or from S_HOLD: drop<=1 only if a response is still outstanding (S_WAIT); otherwise go to S_REQ.
  - From S_WAIT with a same-cycle response: discard it, go to S_REQ.
  - From S_REQ: if the request is accepted the same cycle, that request is treated as outstanding: go to S_WAIT with drop=1. fetch_pc still takes the target.
- The first request after a redirect carries the target address.

Decomposition:
- common_pkg gains: NOP_INSTR constant (32'h0000_0013), fetch_state_t enum {S_REQ, S_WAIT, S_HOLD}, and an if_id_t struct {instruction_t instruction; logic [31:0] pc; logic valid}.
- No sub-module. The hold buffer is a single if_id_t register inside the block.

Test Plan:
- Reset, then memory with ready=1 and 1-cycle latency returning addr>>2: instr_valid rises with pc=0x0, then pc=0x4 and 0x8 on successive responses. Each response has a 2-cycle request-to-output period.
- stall=1 for 5 cycles while a response for pc=0x8 arrives: outputs hold pc=0x4. After stall drops, the next cycle shows pc=0x8. No request is issued during S_HOLD.
- branch_taken with target 0x103 while in S_WAIT: the late response for the old pc is discarded with instr_valid=0. The next request addr is 0x100 and the first valid output is pc=0x100.
- branch_taken in the same cycle as imem_rsp_valid, with stall=1: response discarded, outputs flushed to NOP_WORD/instr_valid=0, next request addr = target.
- imem_req_ready held low 4 cycles: imem_req_valid and imem_req_addr stay stable. The fetch proceeds on accept.
- RESET_PC=0xFFFF_FFFC: fetches 0xFFFF_FFFC then 0x0000_0000. rst asserted while in S_WAIT: instr_valid=0, the next request addr is RESET_PC, and the stale response is ignored.
